zle_dec: RTL and testbench

- Zero run-length decoder; the stage directly downstream of the ZLE encoder.
- Consumes the encoder's 4-bit token stream and expands it back into the 3-bit sample stream.
- Uses the same valid/back-pressure stream protocol on both sides, so it plugs straight onto the encoder's o_d/o_v/o_b port.

---
 rtl/zle_pkg.sv | 37 +++
 rtl/zle_dec_if.sv | 25 ++
 rtl/zle_dec_dp.sv | 59 +++++
 rtl/zle_dec_fsm.sv | 54 +++++
 rtl/zle_dec.sv | 51 +++++
 tb/tb_zle_dec.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/zle_pkg.sv
// Shared definitions for the ZLE (zero run-length) codec.
//   - Sample/run/token widths and the token run-flag bit position.
//   - Decoder FSM state encodings.
//   - Token field helpers, usable by both encoder and decoder code and benches.
// Token layout: [TOK_RUN_BIT] = 1 for a zero run, 0 for a literal;
//               [W_DATA-1:0]  = literal value, or run length minus one.
package zle_pkg;

  localparam int W_DATA      = 3;
  localparam int W_RUN       = W_DATA;
  localparam int W_TOK       = W_DATA + 1;
  localparam int TOK_RUN_BIT = W_TOK - 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // output register empty
    ST_HOLD  = 2'd1,   // one sample presented, nothing owed after it
    ST_RUN   = 2'd2    // zero presented, more zeros owed after it
  } zle_state_e;

  function automatic logic tok_is_run(input logic [W_TOK-1:0] tok);
    return tok[TOK_RUN_BIT];
  endfunction

  function automatic logic [W_DATA-1:0] tok_arg(input logic [W_TOK-1:0] tok);
    return tok[W_DATA-1:0];
  endfunction

  function automatic logic [W_TOK-1:0] mk_lit(input logic [W_DATA-1:0] val);
    return {1'b0, val};
  endfunction

  // len_m1 is the run length minus one (0 encodes a single zero)
  function automatic logic [W_TOK-1:0] mk_run(input logic [W_RUN-1:0] len_m1);
    return {1'b1, len_m1};
  endfunction

endpackage

// File: rtl/zle_dec_if.sv
// Stream bundle around the ZLE decoder.
//   i_d/i_v/i_b : token stream into the decoder (i_b is back-pressure to source)
//   o_d/o_v/o_b : sample stream out of the decoder (o_b is back-pressure from sink)
// master = the environment (token source + sample sink), slave = the decoder.
interface zle_dec_if;
  import zle_pkg::*;

  logic [W_TOK-1:0]  i_d;
  logic              i_v;
  logic              i_b;
  logic [W_DATA-1:0] o_d;
  logic              o_v;
  logic              o_b;

  modport master (
    output i_d, i_v, o_b,
    input  i_b, o_d, o_v
  );

  modport slave (
    input  i_d, i_v, o_b,
    output i_b, o_d, o_v
  );

endinterface

// File: rtl/zle_dec_dp.sv
// Datapath half of the ZLE decoder.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   accept, drain  : strobes from the FSM
//   tok_d          : incoming token
//   o_d            : registered output sample
//   f_run_rem_eq_0 : no zeros owed after the presented sample
//   f_run_rem_eq_1 : exactly one zero owed after the presented sample
module zle_dec_dp
  import zle_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              accept,
  input  logic              drain,
  input  logic [W_TOK-1:0]  tok_d,
  output logic [W_DATA-1:0] o_d,
  output logic              f_run_rem_eq_0,
  output logic              f_run_rem_eq_1
);

  localparam logic [W_RUN-1:0] RUN_ONE = W_RUN'(1);

  logic [W_DATA-1:0] out_data_q, out_data_d;
  logic [W_RUN-1:0]  run_rem_q, run_rem_d;

  assign o_d            = out_data_q;
  assign f_run_rem_eq_0 = (run_rem_q == '0);
  assign f_run_rem_eq_1 = (run_rem_q == RUN_ONE);

  always_comb begin
    out_data_d = out_data_q;
    run_rem_d  = run_rem_q;
    if (accept) begin
      if (tok_is_run(tok_d)) begin
        out_data_d = '0;
        run_rem_d  = tok_arg(tok_d);
      end else begin
        out_data_d = tok_arg(tok_d);
        run_rem_d  = '0;
      end
    end else if (drain && !f_run_rem_eq_0) begin
      // Guarded by run_rem != 0, so the decrement never wraps.
      out_data_d = '0;
      run_rem_d  = run_rem_q - RUN_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q <= '0;
      run_rem_q  <= '0;
    end else begin
      out_data_q <= out_data_d;
      run_rem_q  <= run_rem_d;
    end
  end

endmodule

// File: rtl/zle_dec_fsm.sv
// Control half of the ZLE decoder.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   i_v, o_b          : token valid in, sample back-pressure in
//   tok_run           : current token is a zero-run token
//   tok_arg_zero      : current token argument field is zero
//   f_run_rem_eq_0/1  : run-remaining flags from the datapath
//   i_b               : token back-pressure out
//   o_v               : registered sample valid
//   accept, drain     : token transfer / sample transfer strobes for the datapath
module zle_dec_fsm
  import zle_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_v,
  input  logic o_b,
  input  logic tok_run,
  input  logic tok_arg_zero,
  input  logic f_run_rem_eq_0,
  input  logic f_run_rem_eq_1,
  output logic i_b,
  output logic o_v,
  output logic accept,
  output logic drain
);

  zle_state_e state_q;
  logic       out_full_q;

  assign o_v   = out_full_q;
  assign drain = out_full_q & ~o_b;
  // Depends only on state and o_b, so it can never loop back through i_v.
  assign i_b    = reset | ~f_run_rem_eq_0 | (out_full_q & o_b);
  assign accept = i_v & ~i_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      out_full_q <= 1'b0;
    end else if (accept) begin
      // A run token of argument 0 is a single zero: nothing owed afterwards.
      out_full_q <= 1'b1;
      state_q    <= (tok_run && !tok_arg_zero) ? ST_RUN : ST_HOLD;
    end else if (drain && (state_q == ST_RUN)) begin
      // Last owed zero moves into the output register.
      state_q <= f_run_rem_eq_1 ? ST_HOLD : ST_RUN;
    end else if (drain) begin
      out_full_q <= 1'b0;
      state_q    <= ST_EMPTY;
    end
  end

endmodule

// File: rtl/zle_dec.sv
// ZLE decoder top: expands 4-bit literal / zero-run tokens into 3-bit samples.
// Ports:
//   clock : single clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : token input (i_d/i_v/i_b) and sample output (o_d/o_v/o_b) streams
// o_d/o_v are pure registers; accepted tokens appear on the next cycle.
module zle_dec
  import zle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  zle_dec_if.slave   bus
);

  logic accept;
  logic drain;
  logic tok_run;
  logic tok_arg_zero;
  logic f_run_rem_eq_0;
  logic f_run_rem_eq_1;

  assign tok_run      = tok_is_run(bus.i_d);
  assign tok_arg_zero = (tok_arg(bus.i_d) == '0);

  zle_dec_fsm u_fsm (
    .clock          (clock),
    .reset          (reset),
    .i_v            (bus.i_v),
    .o_b            (bus.o_b),
    .tok_run        (tok_run),
    .tok_arg_zero   (tok_arg_zero),
    .f_run_rem_eq_0 (f_run_rem_eq_0),
    .f_run_rem_eq_1 (f_run_rem_eq_1),
    .i_b            (bus.i_b),
    .o_v            (bus.o_v),
    .accept         (accept),
    .drain          (drain)
  );

  zle_dec_dp u_dp (
    .clock          (clock),
    .reset          (reset),
    .accept         (accept),
    .drain          (drain),
    .tok_d          (bus.i_d),
    .o_d            (bus.o_d),
    .f_run_rem_eq_0 (f_run_rem_eq_0),
    .f_run_rem_eq_1 (f_run_rem_eq_1)
  );

endmodule

// File: tb/tb_zle_dec.sv
// Bench for zle_dec: a per-cycle directed vector table, then a randomized
// round trip through a simple behavioural encoder with random back-pressure.
module tb_zle_dec;
  import zle_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  zle_dec_if bus ();

  zle_dec dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic       v;
    logic       ob;
    logic       chk_out;
    logic       ev;
    logic [2:0] ed;
    logic       eib;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] d, input logic v, input logic ob,
                     input logic chk_out, input logic ev, input logic [2:0] ed, input logic eib);
    vec_t r;
    r.rst = rst; r.d = d; r.v = v; r.ob = ob;
    r.chk_out = chk_out; r.ev = ev; r.ed = ed; r.eib = eib;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  logic [2:0] samples[$];
  logic [3:0] toks[$];

  initial begin
    bus.i_d = 4'h0;
    bus.i_v = 1'b0;
    bus.o_b = 1'b0;

    // rst, d, v, ob, chk_out, exp o_v, exp o_d, exp i_b  (one row per cycle)
    // reset then idle
    add(1, 4'h0, 0, 0, 0, 0, 0, 1);
    add(1, 4'h0, 0, 0, 1, 0, 0, 1);
    add(0, 4'h0, 0, 0, 1, 0, 0, 0);
    // literals 5,3,0 back to back
    add(0, 4'h5, 1, 0, 1, 0, 0, 0);
    add(0, 4'h3, 1, 0, 1, 1, 5, 0);
    add(0, 4'h0, 1, 0, 1, 1, 3, 0);
    add(0, 4'h0, 0, 0, 1, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0, 0);
    // run of 8 zeros, then literal 2 waiting behind it
    add(0, 4'hF, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 4'h2, 1, 0, 1, 1, 0, 1);
    add(0, 4'h2, 1, 0, 1, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 1, 2, 0);
    // minimum run, next token accepted while it drains
    add(0, 4'h8, 1, 0, 1, 0, 2, 0);
    add(0, 4'h6, 1, 0, 1, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 1, 6, 0);
    add(0, 4'h0, 0, 0, 1, 0, 6, 0);
    // run of 4 zeros with a 3-cycle stall after the first
    add(0, 4'hB, 1, 0, 1, 0, 6, 0);
    add(0, 4'h0, 0, 0, 1, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 4'h0, 0, 1, 1, 1, 0, 1);
    add(0, 4'h0, 0, 0, 1, 1, 0, 1);
    add(0, 4'h0, 0, 0, 1, 1, 0, 1);
    add(0, 4'h0, 0, 0, 1, 1, 0, 0);
    // stall on a held literal blocks the next token
    add(0, 4'h7, 1, 1, 1, 0, 0, 0);
    add(0, 4'h1, 1, 1, 1, 1, 7, 1);
    add(0, 4'h1, 1, 0, 1, 1, 7, 0);
    add(0, 4'h0, 0, 0, 1, 1, 1, 0);
    add(0, 4'h0, 0, 0, 1, 0, 1, 0);
    // reset after 3 zeros of an 8-zero run
    add(0, 4'hF, 1, 0, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 4'h0, 0, 0, 1, 1, 0, 1);
    add(1, 4'h0, 0, 0, 1, 1, 0, 1);
    add(0, 4'h1, 1, 0, 1, 0, 0, 0);
    add(0, 4'h0, 0, 0, 1, 1, 1, 0);
    add(0, 4'h0, 0, 0, 1, 0, 1, 0);
    add(0, 4'h0, 0, 0, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset   = vecs[i].rst;
      bus.i_d = vecs[i].d;
      bus.i_v = vecs[i].v;
      bus.o_b = vecs[i].ob;
      #1;
      if (vecs[i].chk_out) begin
        chk("o_v", i, int'(bus.o_v), int'(vecs[i].ev));
        chk("o_d", i, int'(bus.o_d), int'(vecs[i].ed));
      end
      chk("i_b", i, int'(bus.i_b), int'(vecs[i].eib));
      $display("vec %0d rst=%0b tok=%h v=%0b ob=%0b -> o_v=%0b o_d=%0d i_b=%0b",
               i, vecs[i].rst, vecs[i].d, vecs[i].v, vecs[i].ob, bus.o_v, bus.o_d, bus.i_b);
    end

    // Round trip: random samples -> behavioural encoder -> decoder.
    begin
      int zc;
      int guard;
      int nrx;
      bit pres;
      zc = 0;
      for (int n = 0; n < 300; n++) begin
        logic [2:0] s;
        s = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
        if (n % 60 < 12) s = 3'd0;  // force some runs longer than 8
        samples.push_back(s);
        if (s == 3'd0) zc++;
        else begin
          while (zc > 0) begin
            int l;
            l = (zc > 8) ? 8 : zc;
            toks.push_back(mk_run(3'(l - 1)));
            zc -= l;
          end
          toks.push_back(mk_lit(s));
        end
      end
      while (zc > 0) begin
        int l;
        l = (zc > 8) ? 8 : zc;
        toks.push_back(mk_run(3'(l - 1)));
        zc -= l;
      end

      guard = 0;
      nrx = 0;
      pres = 1'b0;
      while (samples.size() > 0 && guard < 10000) begin
        @(negedge clock);
        guard++;
        bus.o_b = ($urandom_range(3) == 0);
        if (!pres && toks.size() > 0 && $urandom_range(3) != 0) pres = 1'b1;
        bus.i_v = pres;
        bus.i_d = pres ? toks[0] : 4'h0;
        #1;
        if (bus.o_v && !bus.o_b) begin
          logic [2:0] e;
          e = samples.pop_front();
          chk("rt_sample", nrx, int'(bus.o_d), int'(e));
          $display("rt %0d o_d=%0d exp=%0d", nrx, bus.o_d, e);
          nrx++;
        end
        if (pres && !bus.i_b) begin
          void'(toks.pop_front());
          pres = 1'b0;
        end
      end
      chk("rt_left", nrx, samples.size(), 0);
      @(negedge clock);
      bus.i_v = 1'b0;
      bus.o_b = 1'b0;
      #1;
      chk("rt_no_extra", nrx, int'(bus.o_v), 0);
      chk("rt_tokens_used", nrx, toks.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
